// File: rtl/mul_signed.sv
// Iterative signed shift-and-add multiplier: one operand pair in, one full-width signed product out.
// Latency: valid_in sampled at edge N -> product/valid_out updated at edge N+B_WIDTH+1.
// Backpressure: none queued; valid_in is only sampled while idle, so it is ignored while busy.
module mul_signed #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic [A_WIDTH-1:0]         multiplicand,
    input  logic [B_WIDTH-1:0]         multiplier,
    output logic                       busy,
    output logic [A_WIDTH+B_WIDTH-1:0] product,
    output logic                       valid_out
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int CNT_W   = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [A_WIDTH-1:0] a_mag;
    logic [B_WIDTH-1:0] b_mag;
    logic               sign;
    logic [P_WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               last_iter;

    assign last_iter = (cnt == CNT_W'(B_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_in) state_nxt = LOOP;
            LOOP:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // The most-negative operand negates to 2^(W-1), which still fits as W-bit unsigned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_mag     <= '0;
            b_mag     <= '0;
            sign      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        a_mag <= multiplicand[A_WIDTH-1] ? (~multiplicand + 1'b1) : multiplicand;
                        b_mag <= multiplier[B_WIDTH-1]   ? (~multiplier + 1'b1)   : multiplier;
                        sign  <= multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                LOOP: begin
                    if (b_mag[cnt]) begin
                        acc <= acc + (P_WIDTH'(a_mag) << cnt);
                    end
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    // product and valid_out rise together on the edge leaving DONE
                    product   <= sign ? (-acc) : acc;
                    valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_signed.sv
// Directed and random checks of mul_signed (8x8): products, latency, busy, reset abort, back-to-back.
module tb_mul_signed;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic [15:0] product;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    localparam int EXP_LAT = 9;   // edges from capture edge to the edge raising valid_out
    localparam int MAX_WAIT = 20;

    mul_signed #(.A_WIDTH(8), .B_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .product      (product),
        .valid_out    (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: issue one pair (caller is #1 after a posedge), return product and latency.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output int lat);
        multiplicand = a;
        multiplier   = b;
        valid_in     = 1'b1;
        @(posedge clk); #1;
        valid_in     = 1'b0;
        multiplicand = 8'hxx;
        multiplier   = 8'hxx;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid_out && lat < MAX_WAIT);
        prod = product;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; multiplicand = 8'd0; multiplier = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat;
        multiplicand = 8'd7; multiplier = 8'hFD; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_capture got=%b exp=1", busy); end
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!valid_out && lat < MAX_WAIT);
        p = product;
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, EXP_LAT); end
        checks++; if (p !== 16'hFFEB) begin errors++; $display("FAIL basic_7x-3 got=%h exp=ffeb", p); end
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        checks++; if (product !== 16'hFFEB) begin errors++; $display("FAIL basic_hold got=%h exp=ffeb", product); end
    endtask

    task automatic test_extremes();
        logic [15:0] p;
        int lat;
        run_op(8'h80, 8'h80, p, lat);
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL ext_-128x-128 got=%h exp=4000", p); end
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL ext_lat1 got=%0d exp=%0d", lat, EXP_LAT); end
        @(posedge clk); #1;
        run_op(8'h80, 8'h7F, p, lat);
        checks++; if (p !== 16'hC080) begin errors++; $display("FAIL ext_-128x127 got=%h exp=c080", p); end
        @(posedge clk); #1;
        run_op(8'h7F, 8'h7F, p, lat);
        checks++; if (p !== 16'h3F01) begin errors++; $display("FAIL ext_127x127 got=%h exp=3f01", p); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        logic [15:0] p;
        int lat;
        int extra;
        run_op(8'h00, 8'hFB, p, lat);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_product got=%h exp=0000", p); end
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", lat, EXP_LAT); end
        extra = 0;
        repeat (12) begin @(posedge clk); #1; if (valid_out) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL zero_single_valid extra_pulses=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int lat;
        int pulses;
        multiplicand = 8'd5; multiplier = 8'd6; valid_in = 1'b1;
        @(posedge clk); #1;
        multiplicand = 8'd9; multiplier = 8'd9;   // held while busy: must be ignored
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!valid_out && lat < MAX_WAIT);
        valid_in = 1'b0;
        p = product;
        checks++; if (p !== 16'h001E) begin errors++; $display("FAIL b2b_first got=%h exp=001e", p); end
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL b2b_first_lat got=%0d exp=%0d", lat, EXP_LAT); end
        run_op(8'd9, 8'd9, p, lat);
        checks++; if (p !== 16'h0051) begin errors++; $display("FAIL b2b_second got=%h exp=0051", p); end
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL b2b_second_lat got=%0d exp=%0d", lat, EXP_LAT); end
        pulses = 0;
        repeat (12) begin @(posedge clk); #1; if (valid_out) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL b2b_no_queued got=%0d exp=0", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        int pulses;
        multiplicand = 8'd12; multiplier = 8'd12; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL rmid_product got=%h exp=0000", product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        #1 reset = 1'b0;
        pulses = 0;
        repeat (12) begin @(posedge clk); #1; if (valid_out) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_no_valid got=%0d exp=0", pulses); end
        run_op(8'hFF, 8'h01, p, lat);
        checks++; if (p !== 16'hFFFF) begin errors++; $display("FAIL rmid_next got=%h exp=ffff", p); end
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL rmid_next_lat got=%0d exp=%0d", lat, EXP_LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic signed [7:0]  a;
        logic signed [7:0]  b;
        logic signed [15:0] e;
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            e = 16'(a) * 16'(b);
            run_op(a, b, p, lat);
            checks++; if (p !== e) begin errors++; $display("FAIL rand_product a=%0d b=%0d got=%h exp=%h", a, b, p, e); end
            checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL rand_latency a=%0d b=%0d got=%0d exp=%0d", a, b, lat, EXP_LAT); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
